// File: rtl/linear_acc_ctrl.sv
// linear_acc_ctrl: sequences one output neuron at a time over CHUNKS input
// beats, reducing each beat across its lanes. It keeps a running sum per
// channel (A and B), adds the per-neuron bias, and presents the result on a
// valid/ready output. Chunk and neuron indices address the weight and bias
// memories upstream.
//
// Optional feature: define LINEAR_ACC_SATURATE_EN to clamp every accumulate
// and the bias add to the signed BIAS_PRECISION range instead of wrapping.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; indices at 0
// ACCUM  | accepting input beats; in_ready high
// BIAS   | one cycle: bias added, output registers loaded
// OUTPUT | out_valid high until out_ready
// DONE   | one-cycle done pulse, then back to IDLE

module linear_acc_ctrl #(
    parameter  int BIAS_PRECISION  = 32,
    parameter  int MUL_PER_FEATURE = 1,
    parameter  int IN_FEATURES     = 64,
    parameter  int OUT_FEATURES    = 16,
    localparam int CHUNKS          = IN_FEATURES / MUL_PER_FEATURE,
    localparam int CW              = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
    localparam int NW              = (OUT_FEATURES > 1) ? $clog2(OUT_FEATURES) : 1
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    output logic                                            busy,
    output logic                                            done,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [MUL_PER_FEATURE-1:0][BIAS_PRECISION-1:0]  in_data_A,
    input  logic [MUL_PER_FEATURE-1:0][BIAS_PRECISION-1:0]  in_data_B,
    input  logic [BIAS_PRECISION-1:0]                       bias_A,
    input  logic [BIAS_PRECISION-1:0]                       bias_B,
    output logic [CW-1:0]                                   chunk_idx,
    output logic [NW-1:0]                                   neuron_idx,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [BIAS_PRECISION-1:0]                       out_data_A,
    output logic [BIAS_PRECISION-1:0]                       out_data_B
);

    localparam int P = BIAS_PRECISION;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_BIAS,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic [P-1:0]   acc_a;
    logic [P-1:0]   acc_b;
    logic [P-1:0]   acc_load_a;
    logic [P-1:0]   acc_load_b;
    logic [P-1:0]   biased_a;
    logic [P-1:0]   biased_b;

    logic           beat;
    logic           out_fire;
    logic           chunk_last;
    logic           neuron_last;
    logic           first_beat;

    // in_ready is a registered copy of (state == ACCUM), so this is the handshake
    assign beat        = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign chunk_last  = (chunk_idx == CW'(CHUNKS - 1));
    assign neuron_last = (neuron_idx == NW'(OUT_FEATURES - 1));
    assign first_beat  = (chunk_idx == '0);

`ifdef LINEAR_ACC_SATURATE_EN

    // Lane sum carries enough headroom for MUL_PER_FEATURE full-scale terms;
    // one more bit covers adding that to a clamped accumulator.
    localparam int SW = P + $clog2(MUL_PER_FEATURE) + 1;
    localparam int AW = SW + 1;

    localparam logic [AW-1:0] SAT_MAX = {{(AW-P+1){1'b0}}, {(P-1){1'b1}}};
    localparam logic [AW-1:0] SAT_MIN = {{(AW-P+1){1'b1}}, {(P-1){1'b0}}};

    function automatic logic [P-1:0] clamp(input logic [AW-1:0] v);
        logic [P-1:0] r;
        if ($signed(v) > $signed(SAT_MAX)) begin
            r = SAT_MAX[P-1:0];
        end else if ($signed(v) < $signed(SAT_MIN)) begin
            r = SAT_MIN[P-1:0];
        end else begin
            r = v[P-1:0];
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] sext_p(input logic [P-1:0] v);
        return {{(AW-P){v[P-1]}}, v};
    endfunction

    function automatic logic [AW-1:0] sext_s(input logic [SW-1:0] v);
        return {{(AW-SW){v[SW-1]}}, v};
    endfunction

    logic [SW-1:0] lane_a;
    logic [SW-1:0] lane_b;

    // Reduce the beat's lanes at extended width so no lane sum can overflow
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < MUL_PER_FEATURE; i++) begin
            lane_a = lane_a + {{(SW-P){in_data_A[i][P-1]}}, in_data_A[i]};
            lane_b = lane_b + {{(SW-P){in_data_B[i][P-1]}}, in_data_B[i]};
        end
    end

    // Clamp the accumulate and bias results back into the signed P-bit range
    always_comb begin
        acc_load_a = first_beat ? clamp(sext_s(lane_a))
                                : clamp(sext_p(acc_a) + sext_s(lane_a));
        acc_load_b = first_beat ? clamp(sext_s(lane_b))
                                : clamp(sext_p(acc_b) + sext_s(lane_b));
        biased_a   = clamp(sext_p(acc_a) + sext_p(bias_A));
        biased_b   = clamp(sext_p(acc_b) + sext_p(bias_B));
    end

`else

    logic [P-1:0] lane_a;
    logic [P-1:0] lane_b;

    // Reduce the beat's lanes; plain modulo 2^P arithmetic
    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < MUL_PER_FEATURE; i++) begin
            lane_a = lane_a + in_data_A[i];
            lane_b = lane_b + in_data_B[i];
        end
    end

    // First beat of a neuron overwrites the accumulator, so no clear cycle is needed
    always_comb begin
        acc_load_a = first_beat ? lane_a : acc_a + lane_a;
        acc_load_b = first_beat ? lane_b : acc_b + lane_b;
        biased_a   = acc_a + bias_A;
        biased_b   = acc_b + bias_B;
    end

`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (beat && chunk_last) begin
                    state_nx = S_BIAS;
                end
            end
            S_BIAS: begin
                state_nx = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (out_fire) begin
                    state_nx = neuron_last ? S_DONE : S_ACCUM;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            busy      <= (state_nx != S_IDLE);
            done      <= (state_nx == S_DONE);
            in_ready  <= (state_nx == S_ACCUM);
            out_valid <= (state_nx == S_OUTPUT);
        end
    end

    // Chunk index advances per accepted beat and wraps after the last one
    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_idx <= '0;
        end else if (beat) begin
            chunk_idx <= chunk_last ? '0 : chunk_idx + 1'b1;
        end
    end

    // Neuron index advances per output handshake and wraps after the last neuron
    always_ff @(posedge clk) begin
        if (rst) begin
            neuron_idx <= '0;
        end else if (out_fire) begin
            neuron_idx <= neuron_last ? '0 : neuron_idx + 1'b1;
        end
    end

    // Accumulators: load on beats, add bias in BIAS, hold on stall cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_a <= '0;
            acc_b <= '0;
        end else if (beat) begin
            acc_a <= acc_load_a;
            acc_b <= acc_load_b;
        end else if (state == S_BIAS) begin
            acc_a <= biased_a;
            acc_b <= biased_b;
        end
    end

    // Output data loads only on entry to OUTPUT, so it is stable while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_A <= '0;
            out_data_B <= '0;
        end else if (state == S_BIAS) begin
            out_data_A <= biased_a;
            out_data_B <= biased_b;
        end
    end

endmodule

// File: tb/tb_linear_acc_ctrl.sv
// Bench for linear_acc_ctrl with MUL_PER_FEATURE=2, IN_FEATURES=4,
// OUT_FEATURES=2, BIAS_PRECISION=32. Stimulus pushes expected results into
// a scoreboard queue; a separate monitor pops on every output handshake.

module tb_linear_acc_ctrl;

    localparam int P    = 32;
    localparam int M    = 2;
    localparam int INF  = 4;
    localparam int OUTF = 2;
    localparam int CH   = INF / M;

    typedef logic [31:0] vec4_t [4];
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          n;
    } exp_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                busy;
    logic                done;
    logic                in_valid;
    logic                in_ready;
    logic [M-1:0][P-1:0] in_data_A;
    logic [M-1:0][P-1:0] in_data_B;
    logic [P-1:0]        bias_A;
    logic [P-1:0]        bias_B;
    logic [0:0]          chunk_idx;
    logic [0:0]          neuron_idx;
    logic                out_valid;
    logic                out_ready;
    logic [P-1:0]        out_data_A;
    logic [P-1:0]        out_data_B;

    int          checks   = 0;
    int          failures = 0;
    exp_t        sbq[$];
    logic [31:0] res_a [OUTF];
    logic [31:0] res_b [OUTF];
    bit          rand_ready = 1'b0;

    bit          pend;
    bit          done_due;
    bit          fire;
    bit          new_due;
    logic [31:0] hold_a;
    logic [31:0] hold_b;
    exp_t        e;

    linear_acc_ctrl #(
        .BIAS_PRECISION (P),
        .MUL_PER_FEATURE(M),
        .IN_FEATURES    (INF),
        .OUT_FEATURES   (OUTF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data_A  (in_data_A),
        .in_data_B  (in_data_B),
        .bias_A     (bias_A),
        .bias_B     (bias_B),
        .chunk_idx  (chunk_idx),
        .neuron_idx (neuron_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_A (out_data_A),
        .out_data_B (out_data_B)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

`ifdef LINEAR_ACC_SATURATE_EN
    function automatic longint sat(input longint x);
        if (x > 64'sd2147483647) return 64'sd2147483647;
        if (x < -64'sd2147483648) return -64'sd2147483648;
        return x;
    endfunction
`endif

    // Reference: total of all lanes plus bias, per the arithmetic rules
    function automatic logic [31:0] model(input vec4_t v, input logic [31:0] bias);
        logic [31:0] res;
`ifdef LINEAR_ACC_SATURATE_EN
        longint r = 0;
        longint s;
        for (int c = 0; c < CH; c++) begin
            s = longint'($signed(v[2*c])) + longint'($signed(v[2*c+1]));
            r = sat((c == 0) ? s : r + s);
        end
        r   = sat(r + longint'($signed(bias)));
        res = r[31:0];
`else
        res = bias;
        for (int i = 0; i < 4; i++) res = res + v[i];
`endif
        return res;
    endfunction

    task automatic rand_vec(output vec4_t v);
        for (int i = 0; i < 4; i++) v[i] = $urandom();
    endtask

    task automatic check_reset_vals();
        check("rst_busy",       32'(busy),       0);
        check("rst_done",       32'(done),       0);
        check("rst_in_ready",   32'(in_ready),   0);
        check("rst_out_valid",  32'(out_valid),  0);
        check("rst_out_a",      out_data_A,      0);
        check("rst_out_b",      out_data_B,      0);
        check("rst_chunk_idx",  32'(chunk_idx),  0);
        check("rst_neuron_idx", 32'(neuron_idx), 0);
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("wait_idle", 32'(busy), 0);
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((sbq.size() != 0 || busy) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue", sbq.size(), 0);
        check("drain_busy", 32'(busy), 0);
    endtask

    task automatic start_layer();
        wait_idle();
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check("start_in_ready", 32'(in_ready), 1);
        check("start_busy", 32'(busy), 1);
    endtask

    task automatic send_beat(input logic [31:0] a0, input logic [31:0] a1,
                             input logic [31:0] b0, input logic [31:0] b1,
                             input bit last, input logic [31:0] ba, input logic [31:0] bb);
        int t = 0;
        @(negedge clk);
        in_valid     = 1'b1;
        in_data_A[0] = a0;
        in_data_A[1] = a1;
        in_data_B[0] = b0;
        in_data_B[1] = b1;
        if (last) begin
            bias_A = ba;
            bias_B = bb;
        end
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("beat_accept_wait", 32'(in_ready), 1);
    endtask

    task automatic do_neuron(input vec4_t a, input vec4_t b, input logic [31:0] ba,
                             input logic [31:0] bb, input int n, input int stall,
                             input bit chk_lat);
        send_beat(a[0], a[1], b[0], b[1], 1'b0, ba, bb);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            in_valid = 1'b0;
            check("stall_chunk_hold", 32'(chunk_idx), 1);
        end
        sbq.push_back('{a: model(a, ba), b: model(b, bb), n: n});
        send_beat(a[2], a[3], b[2], b[3], 1'b1, ba, bb);
        @(negedge clk);
        in_valid = 1'b0;
        if (chk_lat) begin
            check("lat_bias_cycle_valid", 32'(out_valid), 0);
            @(negedge clk);
            check("lat_out_valid", 32'(out_valid), 1);
        end
    endtask

    // Random back-pressure source
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops the scoreboard on each handshake, checks hold and done timing
    initial begin
        pend     = 1'b0;
        done_due = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                pend     = 1'b0;
                done_due = 1'b0;
            end else begin
                fire    = out_valid && out_ready;
                new_due = 1'b0;
                if (pend) begin
                    check("hold_valid", 32'(out_valid), 1);
                    check("hold_data_a", out_data_A, hold_a);
                    check("hold_data_b", out_data_B, hold_b);
                end
                if (done || done_due) check("done_pulse", 32'(done), 32'(done_due));
                if (fire) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output: got %0h/%0h expected none", out_data_A, out_data_B);
                    end else begin
                        e = sbq.pop_front();
                        check("out_a", out_data_A, e.a);
                        check("out_b", out_data_B, e.b);
                        check("out_neuron", 32'(neuron_idx), e.n);
                        res_a[e.n] = out_data_A;
                        res_b[e.n] = out_data_B;
                        new_due    = (e.n == OUTF - 1);
                    end
                end
                pend     = out_valid && !out_ready;
                hold_a   = out_data_A;
                hold_b   = out_data_B;
                done_due = new_due;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec4_t ba_v;
        vec4_t bb_v;
        vec4_t ra;
        vec4_t rb;
        vec4_t ov;
        logic [31:0] exp_a;

        ba_v = '{32'd1, 32'd2, 32'd3, 32'd4};
        bb_v = '{32'd5, 32'd5, 32'd0, 32'd0};
        ov   = '{32'h7FFFFFFF, 32'd1, 32'd0, 32'd0};

        rst       = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data_A = '0;
        in_data_B = '0;
        bias_A    = '0;
        bias_B    = '0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        // Input presented while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid     = 1'b1;
            in_data_A[0] = $urandom();
            in_data_B[1] = $urandom();
            check("idle_in_ready", 32'(in_ready), 0);
        end

        // Basic run on neuron 0, then back-pressure on neuron 1
        out_ready = 1'b1;
        start_layer();
        do_neuron(ba_v, bb_v, 32'd10, 32'hFFFFFFFD, 0, 0, 1'b1);
        @(negedge clk);
        check("basic_a", res_a[0], 32'd20);
        check("basic_b", res_b[0], 32'd7);
        check("basic_neuron_idx", 32'(neuron_idx), 1);

        out_ready = 1'b0;
        rand_vec(ra);
        rand_vec(rb);
        exp_a = model(ra, 32'd77);
        do_neuron(ra, rb, 32'd77, 32'd5, 1, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 1);
            check("bp_in_ready", 32'(in_ready), 0);
            check("bp_data_a", out_data_A, exp_a);
            if (i < 4) @(negedge clk);
        end
        @(negedge clk);
        out_ready = 1'b1;
        check("bp_valid_at_release", 32'(out_valid), 1);
        @(negedge clk);
        check("bp_valid_dropped", 32'(out_valid), 0);
        check("layer_done", 32'(done), 1);
        check("layer_neuron_wrap", 32'(neuron_idx), 0);
        @(negedge clk);
        check("layer_busy_after_done", 32'(busy), 0);
        wait_drain();

        // Input stalls between beats give the same result
        res_a[0] = '0;
        res_b[0] = '0;
        start_layer();
        do_neuron(ba_v, bb_v, 32'd10, 32'hFFFFFFFD, 0, 3, 1'b0);
        rand_vec(ra);
        rand_vec(rb);
        do_neuron(ra, rb, $urandom(), $urandom(), 1, 0, 1'b0);
        wait_drain();
        check("stall_a", res_a[0], 32'd20);
        check("stall_b", res_b[0], 32'd7);

        // Reset after the first beat of neuron 1
        start_layer();
        do_neuron(ba_v, bb_v, 32'd10, 32'hFFFFFFFD, 0, 0, 1'b0);
        rand_vec(ra);
        send_beat(ra[0], ra[1], ra[2], ra[3], 1'b0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_reset_vals();
        check("rst_queue_empty", sbq.size(), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_no_done", 32'(done), 0);
            check("rst_idle", 32'(busy), 0);
        end
        res_a[0] = '0;
        res_b[0] = '0;
        start_layer();
        do_neuron(ba_v, bb_v, 32'd10, 32'hFFFFFFFD, 0, 0, 1'b0);
        rand_vec(ra);
        rand_vec(rb);
        do_neuron(ra, rb, $urandom(), $urandom(), 1, 0, 1'b0);
        wait_drain();
        check("post_rst_a", res_a[0], 32'd20);
        check("post_rst_b", res_b[0], 32'd7);

        // Overflow of the first lane sum
        start_layer();
        rand_vec(rb);
        do_neuron(ov, rb, 32'd0, 32'd0, 0, 0, 1'b0);
        rand_vec(ra);
        rand_vec(rb);
        do_neuron(ra, rb, $urandom(), $urandom(), 1, 0, 1'b0);
        wait_drain();
`ifdef LINEAR_ACC_SATURATE_EN
        check("overflow_a", res_a[0], 32'h7FFFFFFF);
`else
        check("overflow_a", res_a[0], 32'h80000000);
`endif

        // Randomised layers with random back-pressure and stalls
        rand_ready = 1'b1;
        for (int l = 0; l < 6; l++) begin
            start_layer();
            if (l == 2) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            for (int n = 0; n < OUTF; n++) begin
                rand_vec(ra);
                rand_vec(rb);
                do_neuron(ra, rb, $urandom(), $urandom(), n, $urandom_range(0, 2), 1'b0);
            end
            wait_drain();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (4) @(negedge clk);
        check("final_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
